// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - command codes, FSM states and sizes shared by the coprocessor host bridge
package coproc_pkg;

  localparam int MAT_W  = 200;
  localparam int N_ELEM = 25;

  localparam logic [2:0] CMD_NOP      = 3'b000;
  localparam logic [2:0] CMD_LOAD_A   = 3'b001;
  localparam logic [2:0] CMD_LOAD_B   = 3'b010;
  localparam logic [2:0] CMD_EXEC     = 3'b011;
  localparam logic [2:0] CMD_READ_RES = 3'b100;
  localparam logic [2:0] CMD_CLEAR    = 3'b101;

  localparam logic [2:0] OP_SOMA     = 3'b000;
  localparam logic [2:0] OP_SUB      = 3'b001;
  localparam logic [2:0] OP_MULT     = 3'b010;
  localparam logic [2:0] OP_MULT_ESC = 3'b011;
  localparam logic [2:0] OP_DET      = 3'b100;
  localparam logic [2:0] OP_TRANSP   = 3'b101;
  localparam logic [2:0] OP_OPOSTA   = 3'b110;

  localparam logic [1:0] SZ_M2 = 2'b00;
  localparam logic [1:0] SZ_M3 = 2'b01;
  localparam logic [1:0] SZ_M4 = 2'b10;
  localparam logic [1:0] SZ_M5 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } bridge_state_t;

  function automatic logic idx_valid(input logic [4:0] idx);
    return idx < 5'(N_ELEM);
  endfunction

endpackage

// File: rtl/coproc_elem_buffer.sv
// rtl/coproc_elem_buffer.sv - 25x8 element buffer, byte write by index or full flat load, flat and byte read
module coproc_elem_buffer #(
  parameter int MAT_W  = 200,
  parameter int N_ELEM = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [4:0]       i_wr_idx,
  input  logic [7:0]       i_wr_data,
  input  logic             i_load,
  input  logic [MAT_W-1:0] i_load_flat,
  input  logic [4:0]       i_rd_idx,
  output logic [7:0]       o_rd_byte,
  output logic [MAT_W-1:0] o_flat
);

  logic [MAT_W-1:0] r_flat;

  // Element 0 sits in the top byte (row-major, MSB first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flat <= '0;
    end else if (i_clr) begin
      r_flat <= '0;
    end else if (i_load) begin
      r_flat <= i_load_flat;
    end else if (i_wr) begin
      for (int e = 0; e < N_ELEM; e++) begin
        if (i_wr_idx == e[4:0]) r_flat[MAT_W-1-8*e -: 8] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_byte = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      if (i_rd_idx == e[4:0]) o_rd_byte = r_flat[MAT_W-1-8*e -: 8];
    end
  end

  assign o_flat = r_flat;

endmodule

// File: rtl/coproc_host_bridge.sv
// rtl/coproc_host_bridge.sv - HPS command front end driving the coprocessor start/ready handshake
// Optional irq output enabled by defining COPROC_BRIDGE_IRQ_EN.
module coproc_host_bridge #(
  parameter int MAT_W          = 200,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cmd_word,
  input  logic             cmd_wr,
  output logic [31:0]      rd_data,
`ifdef COPROC_BRIDGE_IRQ_EN
  output logic             irq,
`endif
  output logic [MAT_W-1:0] cp_matrix1,
  output logic [MAT_W-1:0] cp_matrix2,
  output logic [4:0]       cp_instruction,
  output logic             cp_start,
  input  logic [MAT_W-1:0] cp_result,
  input  logic             cp_ready,
  input  logic             cp_overflow
);
  import coproc_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_t r_state, w_next;
  logic          r_ready_q, r_done, r_ovf, r_err, r_ovf_cap;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_instr, r_rd_idx;
  logic [7:0]    r_rd_byte;

  logic [2:0] w_op;
  logic [4:0] w_idx;
  logic [7:0] w_data, w_res_byte, w_a_byte, w_b_byte;
  logic [MAT_W-1:0] w_res_flat;
  logic w_busy, w_idx_ok, w_rdy_edge;
  logic w_load_a, w_load_b, w_exec, w_read, w_clear, w_illegal;
  logic w_exec_go, w_cmd_err, w_start, w_capture, w_timeout;
  logic w_unused;

  assign w_op     = cmd_word[31:29];
  assign w_idx    = cmd_word[28:24];
  assign w_data   = cmd_word[7:0];
  assign w_unused = ^{cmd_word[23:8], w_a_byte, w_b_byte, w_res_flat};

  assign w_busy     = (r_state != ST_IDLE);
  assign w_idx_ok   = idx_valid(w_idx);
  assign w_rdy_edge = cp_ready & ~r_ready_q;

  assign w_load_a  = cmd_wr & (w_op == CMD_LOAD_A);
  assign w_load_b  = cmd_wr & (w_op == CMD_LOAD_B);
  assign w_exec    = cmd_wr & (w_op == CMD_EXEC);
  assign w_read    = cmd_wr & (w_op == CMD_READ_RES);
  assign w_clear   = cmd_wr & (w_op == CMD_CLEAR);
  assign w_illegal = cmd_wr & w_op[2] & w_op[1];

  assign w_exec_go = w_exec & ~w_busy;
  assign w_cmd_err = ((w_load_a | w_load_b | w_exec) & w_busy)
                   | ((w_load_a | w_load_b | w_read) & ~w_idx_ok)
                   | w_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // cp_start falls combinationally in the cycle the ready edge is seen.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_exec_go) w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_start = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_rdy_edge) begin
          w_capture = 1'b1;
          w_next    = ST_CAPTURE;
        end else begin
          w_start = 1'b1;
          if (r_cnt == TO_LAST) begin
            w_timeout = 1'b1;
            w_next    = ST_IDLE;
          end
        end
      end
      ST_CAPTURE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_clear) begin
      w_next    = ST_IDLE;
      w_start   = 1'b0;
      w_capture = 1'b0;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_q <= 1'b0;
      r_cnt     <= '0;
      r_instr   <= '0;
      r_ovf_cap <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_byte <= '0;
    end else begin
      r_ready_q <= cp_ready;
      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + CW'(1);
      if (w_exec_go) r_instr   <= cmd_word[4:0];
      if (w_capture) r_ovf_cap <= cp_overflow;
      if (w_clear) begin
        r_ovf_cap <= 1'b0;
        r_done    <= 1'b0;
        r_ovf     <= 1'b0;
        r_err     <= 1'b0;
        r_rd_idx  <= '0;
        r_rd_byte <= '0;
      end else begin
        if (w_exec_go) begin
          r_done <= 1'b0;
          r_ovf  <= 1'b0;
          r_err  <= 1'b0;
        end
        if (w_cmd_err | w_timeout) r_err <= 1'b1;
        if (r_state == ST_CAPTURE) begin
          r_done <= 1'b1;
          r_ovf  <= r_ovf_cap;
        end
        if (w_read) begin
          r_rd_idx  <= w_idx;
          r_rd_byte <= w_res_byte;
        end
      end
    end
  end

`ifdef COPROC_BRIDGE_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_irq <= 1'b0;
    else if (w_clear)                              r_irq <= 1'b0;
    else if ((r_state == ST_CAPTURE) | w_timeout)  r_irq <= 1'b1;
    else if (w_read | w_exec)                      r_irq <= 1'b0;
  end

  assign irq = r_irq;
`endif

  coproc_elem_buffer #(.MAT_W(MAT_W), .N_ELEM(N_ELEM)) u_buf_a (
    .clk(clk), .rst(rst), .i_clr(w_clear),
    .i_wr(w_load_a & ~w_busy & w_idx_ok), .i_wr_idx(w_idx), .i_wr_data(w_data),
    .i_load(1'b0), .i_load_flat('0), .i_rd_idx(5'd0),
    .o_rd_byte(w_a_byte), .o_flat(cp_matrix1)
  );

  coproc_elem_buffer #(.MAT_W(MAT_W), .N_ELEM(N_ELEM)) u_buf_b (
    .clk(clk), .rst(rst), .i_clr(w_clear),
    .i_wr(w_load_b & ~w_busy & w_idx_ok), .i_wr_idx(w_idx), .i_wr_data(w_data),
    .i_load(1'b0), .i_load_flat('0), .i_rd_idx(5'd0),
    .o_rd_byte(w_b_byte), .o_flat(cp_matrix2)
  );

  coproc_elem_buffer #(.MAT_W(MAT_W), .N_ELEM(N_ELEM)) u_buf_res (
    .clk(clk), .rst(rst), .i_clr(w_clear),
    .i_wr(1'b0), .i_wr_idx(5'd0), .i_wr_data(8'd0),
    .i_load(w_capture), .i_load_flat(cp_result), .i_rd_idx(w_idx),
    .o_rd_byte(w_res_byte), .o_flat(w_res_flat)
  );

  assign cp_start       = w_start;
  assign cp_instruction = r_instr;
  assign rd_data        = {r_done, w_busy, r_ovf, r_err, 7'd0, r_rd_idx, 8'd0, r_rd_byte};

endmodule

// File: tb/tb_coproc_host_bridge.sv
// tb/tb_coproc_host_bridge.sv - self-checking bench for coproc_host_bridge
module tb_coproc_host_bridge;
  import coproc_pkg::*;

  logic             clk, rst, cmd_wr, cp_start, cp_ready, cp_overflow;
  logic [31:0]      cmd_word, rd_data;
  logic [MAT_W-1:0] cp_matrix1, cp_matrix2, cp_result;
  logic [4:0]       cp_instruction;
`ifdef COPROC_BRIDGE_IRQ_EN
  logic             irq;
`endif

  coproc_host_bridge #(.MAT_W(MAT_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_word(cmd_word), .cmd_wr(cmd_wr), .rd_data(rd_data),
`ifdef COPROC_BRIDGE_IRQ_EN
    .irq(irq),
`endif
    .cp_matrix1(cp_matrix1), .cp_matrix2(cp_matrix2), .cp_instruction(cp_instruction),
    .cp_start(cp_start), .cp_result(cp_result), .cp_ready(cp_ready), .cp_overflow(cp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_a [N_ELEM];
  logic [7:0] m_b [N_ELEM];
  logic [7:0] m_res [N_ELEM];
  logic [7:0] nxt_res [N_ELEM];
  logic       nxt_ovf;
  logic       m_done, m_ovf, m_err;
  logic [4:0] m_rd_idx;
  logic [7:0] m_rd_byte;

  typedef struct {
    logic [2:0] op;
    logic [4:0] idx;
    logic [7:0] data;
    logic [3:0] nib;
    int         ai;
    logic [7:0] ea;
    int         bi;
    logic [7:0] eb;
  } vec_t;
  vec_t tv [9];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] pack(input logic [7:0] m [N_ELEM]);
    logic [MAT_W-1:0] v;
    v = '0;
    for (int e = 0; e < N_ELEM; e++) v[MAT_W-1-8*e -: 8] = m[e];
    return v;
  endfunction

  function automatic logic [7:0] elem(input logic [MAT_W-1:0] f, input int e);
    return f[MAT_W-1-8*e -: 8];
  endfunction

  function automatic logic [31:0] model_word();
    return {m_done, 1'b0, m_ovf, m_err, 7'd0, m_rd_idx, 8'd0, m_rd_byte};
  endfunction

  task automatic model_clear();
    for (int e = 0; e < N_ELEM; e++) begin
      m_a[e] = 8'h00; m_b[e] = 8'h00; m_res[e] = 8'h00;
    end
    m_done = 0; m_ovf = 0; m_err = 0; m_rd_idx = '0; m_rd_byte = '0;
  endtask

  task automatic apply_idle(input logic [2:0] op, input logic [4:0] idx, input logic [7:0] data);
    case (op)
      CMD_LOAD_A: if (idx < 25) m_a[idx] = data; else m_err = 1;
      CMD_LOAD_B: if (idx < 25) m_b[idx] = data; else m_err = 1;
      CMD_READ_RES: begin
        m_rd_idx  = idx;
        m_rd_byte = (idx < 25) ? m_res[idx] : 8'h00;
        if (idx >= 25) m_err = 1;
      end
      CMD_CLEAR: model_clear();
      3'b110, 3'b111: m_err = 1;
      default: ;
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] idx, input logic [7:0] data);
    cmd_word = {op, idx, 16'h0000, data};
    cmd_wr   = 1'b1;
    @(posedge clk); #1;
    cmd_wr   = 1'b0;
  endtask

  // Coprocessor side: ready held four clk cycles, as a slow-clock period would.
  task automatic pulse_ready(input logic [MAT_W-1:0] res, input logic ovf, input logic expect_drop);
    cp_result = res; cp_overflow = ovf; cp_ready = 1'b1;
    #1;
    if (expect_drop) chk("start_drop_on_edge", cp_start, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    cp_ready = 1'b0; cp_overflow = 1'b0;
  endtask

  task automatic do_exec(input logic [4:0] instr, input int dly);
    send(CMD_EXEC, 5'd0, {3'b000, instr});
    chk("start_n_plus_1", cp_start, 1'b1);
    chk("busy_bit", rd_data[30], 1'b1);
    chk("instr_latch", cp_instruction, instr);
    m_done = 0; m_ovf = 0; m_err = 0;
    for (int c = 0; c <= dly; c++) begin
      @(posedge clk); #1;
      chk("start_held", cp_start, 1'b1);
    end
    pulse_ready(pack(nxt_res), nxt_ovf, 1'b1);
    m_res = nxt_res; m_done = 1; m_ovf = nxt_ovf;
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_word"}, rd_data, model_word());
    chk({nm, "_m1"}, cp_matrix1, pack(m_a));
    chk({nm, "_m2"}, cp_matrix2, pack(m_b));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, d, s;
    logic [2:0] op;
    logic [4:0] idx;
    logic [7:0] data;

    tv[0] = '{CMD_LOAD_B,   5'd24, 8'h7F, 4'b0000, 0, 8'h00, 24, 8'h7F};
    tv[1] = '{CMD_LOAD_B,   5'd25, 8'h11, 4'b0001, 0, 8'h00, 24, 8'h7F};
    tv[2] = '{3'b111,       5'd0,  8'h55, 4'b0001, 0, 8'h00, 24, 8'h7F};
    tv[3] = '{CMD_CLEAR,    5'd0,  8'h00, 4'b0000, 0, 8'h00, 24, 8'h00};
    tv[4] = '{CMD_LOAD_A,   5'd0,  8'h05, 4'b0000, 0, 8'h05, 0,  8'h00};
    tv[5] = '{CMD_LOAD_A,   5'd1,  8'h03, 4'b0000, 1, 8'h03, 0,  8'h00};
    tv[6] = '{CMD_LOAD_A,   5'd5,  8'h02, 4'b0000, 5, 8'h02, 0,  8'h00};
    tv[7] = '{CMD_LOAD_A,   5'd6,  8'h04, 4'b0000, 6, 8'h04, 0,  8'h00};
    tv[8] = '{CMD_READ_RES, 5'd30, 8'h00, 4'b0001, 0, 8'h05, 0,  8'h00};

    rst = 1'b1; cmd_word = '0; cmd_wr = 1'b0;
    cp_ready = 1'b0; cp_result = '0; cp_overflow = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_start", cp_start, 1'b0);
    chk("rst_m1", cp_matrix1, '0);
    chk("rst_m2", cp_matrix2, '0);
    chk("rst_instr", cp_instruction, 5'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send(tv[i].op, tv[i].idx, tv[i].data);
      apply_idle(tv[i].op, tv[i].idx, tv[i].data);
      chk($sformatf("tv%0d_nib", i), rd_data[31:28], tv[i].nib);
      chk($sformatf("tv%0d_a", i), elem(cp_matrix1, tv[i].ai), tv[i].ea);
      chk($sformatf("tv%0d_b", i), elem(cp_matrix2, tv[i].bi), tv[i].eb);
      check_all($sformatf("tv%0d", i));
      if (tv[i].op == CMD_CLEAR) chk("clear_zero_word", rd_data, 32'h0);
    end

    // 2x2 determinant of the top-left corner of A
    d = int'($signed(m_a[0])) * int'($signed(m_a[6])) - int'($signed(m_a[1])) * int'($signed(m_a[5]));
    for (int e = 0; e < N_ELEM; e++) nxt_res[e] = 8'h00;
    nxt_res[0] = d[7:0];
    nxt_ovf = (d > 127) || (d < -128);
    do_exec({OP_DET, SZ_M2}, 2);
    send(CMD_READ_RES, 5'd0, 8'h00);
    apply_idle(CMD_READ_RES, 5'd0, 8'h00);
    chk("det_read", rd_data, 32'h8000000E);

    for (int e = 0; e < N_ELEM; e++) nxt_res[e] = 8'h00;
    nxt_res[0] = 8'h7F;
    nxt_ovf = 1'b1;
    do_exec(5'b10000, 1);
    chk("ovf_nib", rd_data[31:28], 4'b1010);
    send(CMD_READ_RES, 5'd0, 8'h00);
    apply_idle(CMD_READ_RES, 5'd0, 8'h00);
    chk("ovf_read", rd_data, 32'hA000007F);

    nxt_res[0] = 8'h33;
    pulse_ready(pack(nxt_res), 1'b0, 1'b0);
    chk("idle_edge_start", cp_start, 1'b0);
    send(CMD_READ_RES, 5'd0, 8'h00);
    chk("idle_edge_ignored", rd_data, 32'hA000007F);

    send(CMD_EXEC, 5'd0, {3'b000, OP_SOMA, SZ_M3});
    m_done = 0; m_ovf = 0; m_err = 0;
    send(CMD_LOAD_A, 5'd3, 8'hAA);
    m_err = 1;
    chk("busy_load_m1", cp_matrix1, pack(m_a));
    chk("busy_load_nib", rd_data[31:28], 4'b0101);
    send(CMD_READ_RES, 5'd0, 8'h00);
    apply_idle(CMD_READ_RES, 5'd0, 8'h00);
    chk("busy_read_byte", rd_data[7:0], 8'h7F);
    chk("busy_read_nib", rd_data[31:28], 4'b0101);
    for (int e = 0; e < N_ELEM; e++) nxt_res[e] = 8'h00;
    nxt_res[0] = 8'h11;
    pulse_ready(pack(nxt_res), 1'b0, 1'b1);
    m_res = nxt_res; m_done = 1;
    chk("busy_done_nib", rd_data[31:28], 4'b1001);
    send(CMD_READ_RES, 5'd0, 8'h00);
    apply_idle(CMD_READ_RES, 5'd0, 8'h00);
    chk("busy_after_read", rd_data, 32'h90000011);

    send(CMD_EXEC, 5'd0, 8'h00);
    m_done = 0; m_ovf = 0; m_err = 1;
    n = 0;
    while (cp_start && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_start_cycles", n, 17);
    chk("timeout_nib", rd_data[31:28], 4'b0001);
    check_all("timeout");

    send(CMD_EXEC, 5'd0, 8'h01);
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_start", cp_start, 1'b0);
    chk("async_rst_rd", rd_data, 32'h0);
    chk("async_rst_m1", cp_matrix1, '0);
    chk("async_rst_instr", cp_instruction, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    nxt_res[0] = 8'h44;
    pulse_ready(pack(nxt_res), 1'b1, 1'b0);
    chk("late_edge_rd", rd_data, 32'h0);
    chk("late_edge_start", cp_start, 1'b0);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        nxt_ovf = 1'b0;
        for (int e = 0; e < N_ELEM; e++) begin
          s = int'($signed(m_a[e])) + int'($signed(m_b[e]));
          nxt_res[e] = s[7:0];
          if (s > 127 || s < -128) nxt_ovf = 1'b1;
        end
        do_exec({OP_SOMA, 2'($urandom_range(0, 3))}, $urandom_range(0, 8));
        check_all("rnd_exec");
      end else begin
        if (r == 1)       op = CMD_CLEAR;
        else if (r == 2)  op = 3'b110;
        else if (r == 3)  op = 3'b111;
        else if (r <= 5)  op = CMD_NOP;
        else if (r <= 9)  op = CMD_LOAD_A;
        else if (r <= 13) op = CMD_LOAD_B;
        else              op = CMD_READ_RES;
        idx  = 5'($urandom_range(0, 31));
        data = 8'($urandom);
        send(op, idx, data);
        apply_idle(op, idx, data);
        check_all($sformatf("rnd%0d_op%0d_idx%0d", it, op, idx));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
